conv_layer_mem_responder: RTL and testbench
===========================================

// Module: conv_layer_mem_responder
// PURPOSE
//  Memory-side responder for the convolution engine's image/layer-memory interface. Holds the
//  64x64 input image, layer-0 (conv+ReLU) and layer-1 (2x2 max-pool) result memories. Loads the image
//  from a host stream, raises ready, serves iaddr/crd reads and cwr writes while the engine is busy,
//  then streams L0 followed by L1 back to the host for checking.
// PARAMETERS
//  DW    20    data width of all memories and data ports
//  IMG_AW 12   image/L0 address width (4096 words)
//  L1_AW 10    L1 address width (1024 words)
// PORTS
//  clk        in  1   rising-edge clock
//  reset      in  1   synchronous, active-high reset
//  load_valid in  1   host image word valid
//  load_ready out 1   responder accepts image word
//  load_data  in  20  image pixel, stored at sequential address 0..4095
//  ready      out 1   image loaded; engine may start
//  busy       in  1   engine running
//  iaddr      in  12  image read address {row,col}
//  idata      out 20  image read data
//  crd        in  1   layer read strobe
//  caddr_rd   in  12  layer read address
//  cdata_rd   out 20  layer read data
//  cwr        in  1   layer write strobe
//  caddr_wr   in  12  layer write address
//  cdata_wr   in  20  layer write data
//  csel       in  3   layer select: 3'b001 = L0, 3'b011 = L1, others invalid
//  dump_valid out 1   result word valid
//  dump_ready in  1   host accepts result word
//  dump_data  out 20  result word
//  dump_sel   out 1   0 = word from L0, 1 = word from L1
//  dump_addr  out 12  address of dump_data within its layer
//  done       out 1   dump complete (level)
//  err        out 1   sticky protocol error
// BEHAVIOUR
//  Reset: state=LOAD, load_ready=1, ready=0, dump_valid=0, dump_sel=0, dump_addr=0, done=0, err=0,
//   load pointer=0. Memory contents are not cleared. Reset mid-operation aborts everything -> LOAD.
//  FSM: LOAD -> START -> RUN -> DUMP_L0 -> DUMP_L1 -> DONE (DONE holds until reset).
//  LOAD: load_valid&&load_ready writes img[ptr], ptr++. Word 4095 accepted -> START, load_ready=0 next cycle.
//  START: ready=1 (registered) until busy sampled 1 -> RUN, ready=0 next cycle.
//  RUN: reads are combinational, zero latency: idata=img[iaddr]; cdata_rd = L0[caddr_rd] if csel==001,
//   L1[caddr_rd[9:0]] if csel==011, else 0; cdata_rd=0 when crd=0. idata=0 outside RUN.
//  Writes commit at posedge when cwr=1: csel==001 -> L0[caddr_wr]; csel==011 -> L1[caddr_wr[9:0]].
//  Simultaneous crd and cwr to the same word: read returns OLD value (write-after-read).
//  err set (sticky) on: cwr or crd with csel not 001/011; csel==011 with addr[11:10]!=0; cwr/crd outside RUN
//   (operation ignored, nothing written).
//  busy 1->0 in RUN -> DUMP_L0 with dump_addr=0, dump_sel=0.
//  DUMP_*: dump_valid=1; dump_data = selected layer[dump_addr] (combinational from registered address).
//   Transfer on dump_valid&&dump_ready -> dump_addr++. dump_data/addr/sel stable while valid&&!ready.
//   L0 addr 4095 transferred -> DUMP_L1, dump_sel=1, dump_addr=0. L1 addr 1023 transferred -> DONE:
//   dump_valid=0, done=1.
//  Image pixels are opaque DW-bit words; no arithmetic performed.
// TESTING
//  1 Load img[i]=i, hold load_valid -> 4096 accepts in 4096 cycles, ready=1 cycle after last, load_ready=0.
//  2 busy=1 while ready -> ready drops next cycle; iaddr=12'h041 -> idata=20'h00041 same cycle.
//  3 cwr csel=001 caddr_wr=5 data=20'hABCDE, next cycle crd csel=001 caddr_rd=5 -> cdata_rd=20'hABCDE;
//    same-cycle read+write of addr 7 returns prior value.
//  4 cwr csel=011 addr 12'h3FF data 20'h12345 ok; csel=010 or csel=011 addr 12'h400 -> err=1, no write.
//  5 busy falls -> 4096 L0 then 1024 L1 words, dump_sel toggles at L1 addr 0; dump_ready toggled
//    randomly -> data held stable; done=1 after L1 addr 1023.
//  6 reset asserted mid-DUMP_L0 -> next cycle state LOAD, load_ready=1, dump_valid=0, done=0, err=0.

Source files
------------

// File: rtl/conv_layer_mem_responder.sv
// Memory-side responder for the convolution engine: holds the input image and the
// L0/L1 result memories, loads the image from the host and dumps results back.
`timescale 1ns/1ps
module conv_layer_mem_responder #(
    parameter int DW     = 20,
    parameter int IMG_AW = 12,
    parameter int L1_AW  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DW-1:0]     load_data,
    output logic              ready,
    input  logic              busy,
    input  logic [IMG_AW-1:0] iaddr,
    output logic [DW-1:0]     idata,
    input  logic              crd,
    input  logic [IMG_AW-1:0] caddr_rd,
    output logic [DW-1:0]     cdata_rd,
    input  logic              cwr,
    input  logic [IMG_AW-1:0] caddr_wr,
    input  logic [DW-1:0]     cdata_wr,
    input  logic [2:0]        csel,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DW-1:0]     dump_data,
    output logic              dump_sel,
    output logic [IMG_AW-1:0] dump_addr,
    output logic              done,
    output logic              err
);
    localparam int IMG_N = 1 << IMG_AW;
    localparam int L1_N  = 1 << L1_AW;
    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    typedef enum logic [2:0] {
        S_LOAD, S_START, S_RUN, S_DUMP_L0, S_DUMP_L1, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IMG_AW-1:0] ptr_q, ptr_d;
    logic [IMG_AW-1:0] dump_addr_q, dump_addr_d;
    logic              err_q, err_d;

    logic [DW-1:0] img_mem [IMG_N];
    logic [DW-1:0] l0_mem  [IMG_N];
    logic [DW-1:0] l1_mem  [L1_N];

    logic run, load_fire, wr_l0, wr_l1, wr_ok, rd_ok;

    assign run       = (state_q == S_RUN);
    assign load_fire = (state_q == S_LOAD) && load_valid;
    // L1 is only 1024 words deep, so its accesses must keep the upper address bits clear
    assign wr_l0 = (csel == CSEL_L0);
    assign wr_l1 = (csel == CSEL_L1) && (caddr_wr[IMG_AW-1:L1_AW] == '0);
    assign wr_ok = wr_l0 || wr_l1;
    assign rd_ok = (csel == CSEL_L0) ||
                   ((csel == CSEL_L1) && (caddr_rd[IMG_AW-1:L1_AW] == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_LOAD;
            ptr_q       <= '0;
            dump_addr_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            dump_addr_q <= dump_addr_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        dump_addr_d = dump_addr_q;
        err_d       = err_q;
        case (state_q)
            S_LOAD: begin
                if (load_valid) begin
                    ptr_d = ptr_q + 1'b1;
                    if (&ptr_q) state_d = S_START;
                end
            end
            S_START: begin
                if (busy) state_d = S_RUN;
            end
            S_RUN: begin
                if (!busy) begin
                    state_d     = S_DUMP_L0;
                    dump_addr_d = '0;
                end
            end
            S_DUMP_L0: begin
                if (dump_ready) begin
                    if (&dump_addr_q) begin
                        state_d     = S_DUMP_L1;
                        dump_addr_d = '0;
                    end else begin
                        dump_addr_d = dump_addr_q + 1'b1;
                    end
                end
            end
            S_DUMP_L1: begin
                if (dump_ready) begin
                    if (&dump_addr_q[L1_AW-1:0]) state_d = S_DONE;
                    else                          dump_addr_d = dump_addr_q + 1'b1;
                end
            end
            default: ;
        endcase
        if ((cwr || crd) && !run) err_d = 1'b1;
        if (run && cwr && !wr_ok) err_d = 1'b1;
        if (run && crd && !rd_ok) err_d = 1'b1;
    end

    // Memories are never cleared; reset only suppresses writes in its own cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (load_fire)           img_mem[ptr_q]                <= load_data;
            if (run && cwr && wr_l0) l0_mem[caddr_wr]              <= cdata_wr;
            if (run && cwr && wr_l1) l1_mem[caddr_wr[L1_AW-1:0]]   <= cdata_wr;
        end
    end

    always_comb begin
        cdata_rd = '0;
        if (run && crd) begin
            if (csel == CSEL_L0)      cdata_rd = l0_mem[caddr_rd];
            else if (csel == CSEL_L1) cdata_rd = l1_mem[caddr_rd[L1_AW-1:0]];
        end
    end

    assign idata      = run ? img_mem[iaddr] : '0;
    assign load_ready = (state_q == S_LOAD);
    assign ready      = (state_q == S_START);
    assign dump_valid = (state_q == S_DUMP_L0) || (state_q == S_DUMP_L1);
    assign dump_sel   = (state_q == S_DUMP_L1);
    assign dump_addr  = dump_addr_q;
    assign done       = (state_q == S_DONE);
    assign err        = err_q;

    always_comb begin
        dump_data = '0;
        if (state_q == S_DUMP_L0)      dump_data = l0_mem[dump_addr_q];
        else if (state_q == S_DUMP_L1) dump_data = l1_mem[dump_addr_q[L1_AW-1:0]];
    end
endmodule

// File: tb/tb_conv_layer_mem_responder.sv
// Directed bench for conv_layer_mem_responder: load, run-time access, error cases,
// full result dump with random backpressure, and reset during the dump.
`timescale 1ns/1ps
module tb_conv_layer_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid, load_ready;
    logic [19:0] load_data;
    logic        ready, busy;
    logic [11:0] iaddr;
    logic [19:0] idata;
    logic        crd, cwr;
    logic [11:0] caddr_rd, caddr_wr;
    logic [19:0] cdata_rd, cdata_wr;
    logic [2:0]  csel;
    logic        dump_valid, dump_ready, dump_sel, done, err;
    logic [19:0] dump_data;
    logic [11:0] dump_addr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    conv_layer_mem_responder dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
        .dump_sel(dump_sel), .dump_addr(dump_addr), .done(done), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [19:0] l0_pat(input int a);
        logic [11:0] a12;
        a12 = a[11:0];
        return {8'h0C, a12};
    endfunction

    function automatic logic [19:0] l1_pat(input int a);
        logic [9:0] a10;
        a10 = a[9:0];
        return {10'h2A5, a10};
    endfunction

    task automatic load_image(input int offset);
        int acc = 0;
        int cyc = 0;
        logic accepted;
        load_valid = 1'b1;
        while (acc < 4096 && cyc < 5000) begin
            load_data = 20'(acc + offset);
            accepted  = load_ready;
            @(negedge clk);
            if (accepted) acc++;
            cyc++;
        end
        load_valid = 1'b0;
        check("load_accepts", acc, 4096);
        check("load_cycles", cyc, 4096);
        check("ready_after_load", ready, 1);
        check("load_ready_after_load", load_ready, 0);
    endtask

    initial begin
        int xfers, idx, cyc;
        logic esel;
        reset = 1'b1; load_valid = 1'b0; load_data = '0; busy = 1'b0; iaddr = '0;
        crd = 1'b0; cwr = 1'b0; caddr_rd = '0; caddr_wr = '0; cdata_wr = '0;
        csel = 3'b000; dump_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_load_ready", load_ready, 1);
        check("rst_ready", ready, 0);
        check("rst_dump_valid", dump_valid, 0);
        check("rst_dump_sel", dump_sel, 0);
        check("rst_dump_addr", dump_addr, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset = 1'b0;

        load_image(0);
        iaddr = 12'h041;
        #1 check("idata_outside_run", idata, 0);

        busy = 1'b1;
        @(negedge clk);
        check("ready_drops", ready, 0);
        check("idata_041", idata, 20'h00041);
        iaddr = 12'hFFF;
        #1 check("idata_fff", idata, 20'h00FFF);

        csel = 3'b001; cwr = 1'b1; caddr_wr = 12'd5; cdata_wr = 20'hABCDE;
        @(negedge clk);
        cwr = 1'b0; crd = 1'b1; caddr_rd = 12'd5;
        #1 check("l0_rd_after_wr", cdata_rd, 20'hABCDE);
        @(negedge clk);
        crd = 1'b0; cwr = 1'b1; caddr_wr = 12'd7; cdata_wr = 20'h11111;
        @(negedge clk);
        cdata_wr = 20'h22222; crd = 1'b1; caddr_rd = 12'd7;
        #1 check("war_old_value", cdata_rd, 20'h11111);
        @(negedge clk);
        cwr = 1'b0;
        #1 check("war_new_value", cdata_rd, 20'h22222);
        crd = 1'b0;
        #1 check("rd_idle_zero", cdata_rd, 0);
        check("err_clean_l0", err, 0);

        csel = 3'b011; cwr = 1'b1; caddr_wr = 12'h3FF; cdata_wr = 20'h12345;
        @(negedge clk);
        cwr = 1'b0; crd = 1'b1; caddr_rd = 12'h3FF;
        #1 check("l1_rd_3ff", cdata_rd, 20'h12345);
        check("err_clean_l1", err, 0);
        crd = 1'b0; cwr = 1'b1; caddr_wr = 12'h000; cdata_wr = 20'hAAAAA;
        @(negedge clk);
        csel = 3'b010; caddr_wr = 12'h3FF; cdata_wr = 20'h00000;
        @(negedge clk);
        cwr = 1'b0;
        check("err_bad_csel", err, 1);
        csel = 3'b011; crd = 1'b1; caddr_rd = 12'h3FF;
        #1 check("bad_csel_nowrite", cdata_rd, 20'h12345);
        crd = 1'b0; cwr = 1'b1; caddr_wr = 12'h400; cdata_wr = 20'h55555;
        @(negedge clk);
        cwr = 1'b0; crd = 1'b1; caddr_rd = 12'h000;
        #1 check("l1_hiaddr_nowrite", cdata_rd, 20'hAAAAA);
        crd = 1'b0;

        csel = 3'b001; cwr = 1'b1;
        for (int a = 0; a < 4096; a++) begin
            caddr_wr = 12'(a); cdata_wr = l0_pat(a);
            @(negedge clk);
        end
        csel = 3'b011;
        for (int a = 0; a < 1024; a++) begin
            caddr_wr = 12'(a); cdata_wr = l1_pat(a);
            @(negedge clk);
        end
        cwr = 1'b0; csel = 3'b000;

        busy = 1'b0;
        @(negedge clk);
        xfers = 0; idx = 0; cyc = 0; esel = 1'b0;
        while (!done && cyc < 20000) begin
            check("dump_valid", dump_valid, 1);
            check("dump_sel", dump_sel, esel);
            check("dump_addr", dump_addr, idx);
            check("dump_data", dump_data, esel ? l1_pat(idx) : l0_pat(idx));
            dump_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            if (dump_ready) begin
                xfers++;
                idx++;
                if (!esel && idx == 4096) begin
                    esel = 1'b1;
                    idx  = 0;
                end
            end
        end
        check("dump_in_budget", cyc < 20000, 1);
        check("dump_xfers", xfers, 5120);
        check("done_set", done, 1);
        check("valid_after_done", dump_valid, 0);
        dump_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("done_holds", done, 1);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        load_image(1);
        crd = 1'b1; csel = 3'b001;
        @(negedge clk);
        crd = 1'b0;
        check("err_rd_outside_run", err, 1);
        busy = 1'b1;
        @(negedge clk);
        iaddr = 12'h041;
        #1 check("idata_reload", idata, 20'h00042);
        busy = 1'b0;
        @(negedge clk);
        dump_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_dump_valid", dump_valid, 1);
        check("mid_dump_addr", dump_addr, 5);
        reset = 1'b1;
        @(negedge clk);
        check("abort_load_ready", load_ready, 1);
        check("abort_dump_valid", dump_valid, 0);
        check("abort_done", done, 0);
        check("abort_err", err, 0);
        check("abort_ready", ready, 0);
        check("abort_dump_addr", dump_addr, 0);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
